// File: rtl/hls_macc_vec.sv
// hls_macc_vec: ap_ctrl_hs signed multiply-accumulate over LANES packed operand pairs, one lane per cycle.
// Define HLS_MACC_VEC_SAT_EN to make each lane add saturate instead of wrap.
module hls_macc_vec #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int ACC_W  = 64
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [1:0]              mode,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic [ACC_W-1:0]        in_c,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_acc_ap_vld,
  output logic                    out_ovf,
  output logic [31:0]             ap_return
);

  localparam int LANE_CW = $clog2(LANES) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    MAC  = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t                   state, state_nxt;
  logic [LANES*DATA_W-1:0]  a_reg, b_reg;
  logic [1:0]               mode_reg;
  logic [LANE_CW-1:0]       lane_cnt;
  logic signed [ACC_W-1:0]  acc, acc_hold;
  logic                     ovf;
  logic                     last_lane;

  logic signed [DATA_W-1:0]   a_i, b_i;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, addend, sum, acc_nxt;
  logic                       lane_ovf;

`ifdef HLS_MACC_VEC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  assign last_lane = (lane_cnt == LANE_CW'(LANES - 1));
  assign ap_return = out_acc[31:0];

  // Operand registers shift down one lane per MAC cycle, so the current lane is always in the low slot.
  always_comb begin
    a_i      = a_reg[DATA_W-1:0];
    b_i      = (mode_reg == 2'b10) ? a_reg[DATA_W-1:0] : b_reg[DATA_W-1:0];
    prod     = a_i * b_i;
    prod_ext = ACC_W'(prod);
    addend   = (mode_reg == 2'b11) ? -prod_ext : prod_ext;
    sum      = acc + addend;
    lane_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef HLS_MACC_VEC_SAT_EN
    if (lane_ovf)
      acc_nxt = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    else
      acc_nxt = sum;
`else
    acc_nxt = sum;
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    ap_done        = 1'b0;
    ap_ready       = 1'b0;
    out_acc_ap_vld = 1'b0;
    ap_idle        = 1'b0;
    case (state)
      IDLE: begin
        ap_idle = !ap_start;
        if (ap_start)
          state_nxt = MAC;
      end
      MAC: begin
        if (last_lane)
          state_nxt = DONE;
      end
      DONE: begin
        ap_done        = 1'b1;
        ap_ready       = 1'b1;
        out_acc_ap_vld = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results are published on the final lane edge so out_acc is already valid while ap_done is high.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= 2'b00;
      lane_cnt <= '0;
      acc      <= '0;
      acc_hold <= '0;
      ovf      <= 1'b0;
      out_acc  <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            mode_reg <= mode;
            lane_cnt <= '0;
            ovf      <= 1'b0;
            acc      <= (mode == 2'b01) ? acc_hold : in_c;
          end
        end
        MAC: begin
          acc      <= acc_nxt;
          ovf      <= ovf | lane_ovf;
          a_reg    <= a_reg >> DATA_W;
          b_reg    <= b_reg >> DATA_W;
          lane_cnt <= lane_cnt + LANE_CW'(1);
          if (last_lane) begin
            out_acc  <= acc_nxt;
            acc_hold <= acc_nxt;
            out_ovf  <= ovf | lane_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hls_macc_vec.md
Name: hls_macc_vec

Overview:
- Parametrised successor to the fixed-function MAC kernels: a multi-cycle signed multiply-accumulate engine over LANES packed operand pairs.
- Uses the ap_ctrl_hs block handshake and ap_vld output qualifiers.
- Time-multiplexes one multiplier across lanes, one lane per cycle.
- Supports four accumulate modes and a persistent accumulator for chained dot products.

Parameters:
- DATA_W, 32, operand width (signed two's complement)
- LANES, 8, operand pairs per call (>=1)
- ACC_W, 64, accumulator/result width (>= 2*DATA_W)

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  synchronous active-low reset
- ap_start  in  1  start request
- ap_done  out  1  call complete (1-cycle pulse)
- ap_idle  out  1  block idle
- ap_ready  out  1  ready for next call (same cycle as ap_done)
- mode  in  2  00 dot, 01 chained dot, 10 sum-of-squares, 11 negative dot
- in_a  in  LANES*DATA_W  operand A, lane 0 in bits [DATA_W-1:0]
- in_b  in  LANES*DATA_W  operand B, same packing
- in_c  in  ACC_W  bias/initial value
- out_acc  out  ACC_W  result
- out_acc_ap_vld  out  1  out_acc valid strobe
- out_ovf  out  1  overflow/saturation flag for last call
- ap_return  out  32  out_acc[31:0]

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst_n is synchronous, active-low.
- Reset values: state IDLE, acc and acc_hold 0, out_acc 0, out_ovf 0, ap_return 0, ap_done/ap_ready/out_acc_ap_vld 0.
- One-hot FSM: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - ap_idle = IDLE & !ap_start.
  - On ap_start=1 (accept edge), register in_a, in_b, in_c and mode, clear lane counter and ovf, and initialise acc:
    - modes 00/10/11: sign-extended in_c
    - mode 01: acc_hold
  - Inputs are not sampled after the accept edge.
- MAC: exactly LANES cycles, lane i on cycle i (i = 0..LANES-1).
  - p = a_i*b_i (mode 00/01), a_i*a_i (10), -(a_i*b_i) (11).
  - Full 2*DATA_W signed product, sign-extended to ACC_W, then acc += p.
  - Default arithmetic wraps modulo 2^ACC_W.
  - Leave MAC after lane LANES-1.
- DONE: one cycle.
  - ap_done = ap_ready = out_acc_ap_vld = 1.
  - out_acc, ap_return and acc_hold update from acc at the DONE clock edge and hold until the next DONE.
  - Next state is IDLE.
  - ap_start is ignored in DONE, so a new call is accepted no earlier than the following IDLE cycle.
- Latency: accept edge at cycle 0, ap_done high in cycle LANES+1. With ap_start held high, back-to-back calls complete every LANES+2 cycles.
- out_ovf (default build): set if any lane add produced a signed ACC_W overflow (operand signs equal, result sign differs). Informational only.
- Reset mid-call: the FSM returns to IDLE and acc_hold clears. No ap_done, no ap_vld, and no partial result becomes visible.
- mode changes during MAC have no effect (mode is registered at accept).
- Lane counter is $clog2(LANES)+1 bits wide. LANES=1 gives one MAC cycle.

Optional Feature:
- Macro: HLS_MACC_VEC_SAT_EN.
- Defined: each lane add saturates to the signed ACC_W max or min on overflow. Subsequent lanes continue from the saturated value. out_ovf is sticky for the call.
- Undefined: wrap-around arithmetic. out_ovf reports wrap occurrence.
- Latency is identical in both builds.

Test Plan:
- Reset: hold ap_rst_n=0 for 2 cycles with ap_start=0 -> ap_idle=1, ap_done=0, out_acc=0, out_ovf=0. Mode 01 with a=b={1,1,1,1}, c=0 afterwards -> out_acc=4.
- Dot: LANES=4, mode 00, a={1,2,3,4}, b={5,6,7,8}, c=10 -> out_acc=80, ap_return=80, ap_done and vld a single pulse at cycle 5 after accept.
- Chain/modes:
  - Mode 01 after the Dot test, a=b={1,1,1,1} -> 84.
  - Then mode 10, a={-3,4,0,0}, c=0 -> 25.
  - Then mode 11, a={-2,0,0,0}, b={3,0,0,0}, c=0 -> 6.
- Overflow: LANES=4, ACC_W=64, all a,b=0x80000000, c=0, mode 00.
  - Wrap build: out_acc=0, out_ovf=1.
  - HLS_MACC_VEC_SAT_EN build: out_acc=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Mid-call reset: assert ap_rst_n=0 on MAC cycle 2 -> no ap_done, ap_idle=1 once ap_start=0, out_acc=0. A following mode 01 call with a=b={1,1,1,1}, c=0 returns 4.
- Streaming: ap_start held high for 3 calls, LANES=4 -> ap_done pulses every 6 cycles, each result correct, ap_idle=0 throughout.
